// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
// Module   : muldiv_unit_pkg
// Purpose  : Shared ALU op codes and WIDTH-independent constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

  localparam int OP_W = 5;

  // Base integer ALU codes; the M-extension block starts at 16.
  localparam logic [OP_W-1:0] ALU_ADD_OP    = 5'd0;
  localparam logic [OP_W-1:0] ALU_SUB_OP    = 5'd1;
  localparam logic [OP_W-1:0] ALU_MUL_OP    = 5'd16;
  localparam logic [OP_W-1:0] ALU_MULH_OP   = 5'd17;
  localparam logic [OP_W-1:0] ALU_MULHSU_OP = 5'd18;
  localparam logic [OP_W-1:0] ALU_MULHU_OP  = 5'd19;
  localparam logic [OP_W-1:0] ALU_DIV_OP    = 5'd20;
  localparam logic [OP_W-1:0] ALU_DIVU_OP   = 5'd21;
  localparam logic [OP_W-1:0] ALU_REM_OP    = 5'd22;
  localparam logic [OP_W-1:0] ALU_REMU_OP   = 5'd23;

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return op inside {ALU_MUL_OP, ALU_MULH_OP, ALU_MULHSU_OP, ALU_MULHU_OP};
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return op inside {ALU_DIV_OP, ALU_DIVU_OP, ALU_REM_OP, ALU_REMU_OP};
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_sign_ctl.sv
// ============================================================================
// Module   : muldiv_sign_ctl
// Purpose  : Operand magnitudes, result-sign flags and fast-path result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_sign_ctl
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_abs,
  output logic [WIDTH-1:0] b_abs,
  output logic             neg_main,
  output logic             neg_rem,
  output logic             fast_sel,
  output logic [WIDTH-1:0] fast_val
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic w_a_signed;
  logic w_b_signed;
  logic w_a_neg;
  logic w_b_neg;

  always_comb begin
    w_a_signed = op inside {ALU_MULH_OP, ALU_MULHSU_OP, ALU_DIV_OP, ALU_REM_OP};
    w_b_signed = op inside {ALU_MULH_OP, ALU_DIV_OP, ALU_REM_OP};
    w_a_neg    = w_a_signed & a[WIDTH-1];
    w_b_neg    = w_b_signed & b[WIDTH-1];
    a_abs      = w_a_neg ? -a : a;
    b_abs      = w_b_neg ? -b : b;
    // Shared by product and quotient; remainder follows the dividend.
    neg_main   = w_a_neg ^ w_b_neg;
    neg_rem    = w_a_neg;

    fast_sel = 1'b0;
    fast_val = '0;
    if (!is_mul_op(op) && !is_div_op(op)) begin
      fast_sel = 1'b1;
    end else if (is_div_op(op) && (b == '0)) begin
      fast_sel = 1'b1;
      fast_val = (op inside {ALU_DIV_OP, ALU_DIVU_OP}) ? '1 : a;
    end else if ((op inside {ALU_DIV_OP, ALU_REM_OP}) && (a == MIN_NEG) && (b == '1)) begin
      fast_sel = 1'b1;
      fast_val = (op == ALU_DIV_OP) ? MIN_NEG : '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit with busy/done handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;

  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH-1:0] w_fast_val;
  logic             w_neg_main;
  logic             w_neg_rem;
  logic             w_fast_sel;

  logic [OP_W-1:0]    r_op;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_neg_main;
  logic               r_neg_rem;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_part;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_acc_neg;
  logic [WIDTH-1:0]   w_rem_hi;
  logic [WIDTH-1:0]   w_fix;

  muldiv_sign_ctl #(.WIDTH(WIDTH)) u_sign_ctl (
    .op       (op),
    .a        (a),
    .b        (b),
    .a_abs    (w_a_abs),
    .b_abs    (w_b_abs),
    .neg_main (w_neg_main),
    .neg_rem  (w_neg_rem),
    .fast_sel (w_fast_sel),
    .fast_val (w_fast_val)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: w_accept = start;
      S_CALC: if (r_cnt == CNT_LAST) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_accept    = start;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_accept) begin
      w_state_nxt = w_fast_sel ? S_DONE : S_CALC;
    end
  end

  // Accumulator: multiply keeps {partial product, multiplier}, divide keeps
  // {remainder, dividend/quotient}; both shift one bit per CALC cycle.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_div_part = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_diff = w_div_part - {1'b0, r_opnd};
    if (is_mul_op(r_op)) begin
      w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
    end else if (!w_div_diff[WIDTH]) begin
      w_acc_nxt = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_nxt = {w_div_part[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    w_acc_neg = r_neg_main ? -r_acc : r_acc;
    w_rem_hi  = r_acc[2*WIDTH-1:WIDTH];
    case (r_op)
      ALU_MUL_OP, ALU_DIV_OP, ALU_DIVU_OP:       w_fix = w_acc_neg[WIDTH-1:0];
      ALU_MULH_OP, ALU_MULHSU_OP, ALU_MULHU_OP:  w_fix = w_acc_neg[2*WIDTH-1:WIDTH];
      ALU_REM_OP, ALU_REMU_OP:                   w_fix = r_neg_rem ? -w_rem_hi : w_rem_hi;
      default:                                   w_fix = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op       <= '0;
      r_opnd     <= '0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_op       <= op;
        r_neg_main <= w_neg_main;
        r_neg_rem  <= w_neg_rem;
        r_cnt      <= '0;
        r_opnd     <= is_mul_op(op) ? w_a_abs : w_b_abs;
        r_acc      <= {{WIDTH{1'b0}}, (is_mul_op(op) ? w_b_abs : w_a_abs)};
        busy       <= !w_fast_sel;
        if (w_fast_sel) begin
          result <= w_fast_val;
          done   <= 1'b1;
        end
      end else begin
        case (r_state)
          S_CALC: begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
          end
          S_FIX: begin
            result <= w_fix;
            done   <= 1'b1;
            busy   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed, table-driven checks of muldiv_unit plus corner sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]   op;
  logic [W-1:0] result;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .op     (op),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  typedef struct {
    string        name;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
    int           bsy;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Edges are counted from the accepting edge (=1) to the edge after which done is seen.
  task automatic run_op(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] res, output int edges, output int busy_n);
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock); #1;
    start  = 1'b0;
    edges  = 1;
    busy_n = 0;
    while (!done && edges < 200) begin
      if (busy) busy_n++;
      @(posedge clock); #1;
      edges++;
    end
    if (busy) busy_n++;
    res = result;
  endtask

  vec_t         vecs [17];
  logic [W-1:0] res;
  logic [W-1:0] held;
  int           edges;
  int           busy_n;
  int           ndone;
  int           done_at [3];

  initial begin
    vecs[0]  = '{"mul_7_m3",      ALU_MUL_OP,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 33};
    vecs[1]  = '{"mulhu_max",     ALU_MULHU_OP,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 33};
    vecs[2]  = '{"mulhsu_m1_max", ALU_MULHSU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 33};
    vecs[3]  = '{"div_m7_2",      ALU_DIV_OP,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 33};
    vecs[4]  = '{"rem_m7_2",      ALU_REM_OP,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 33};
    vecs[5]  = '{"divu_100_7",    ALU_DIVU_OP,   32'd100,      32'd7,        32'd14,       34, 33};
    vecs[6]  = '{"divu_by0",      ALU_DIVU_OP,   32'd1234,     32'd0,        32'hFFFFFFFF, 1,  0};
    vecs[7]  = '{"rem_5_by0",     ALU_REM_OP,    32'd5,        32'd0,        32'd5,        1,  0};
    vecs[8]  = '{"div_ovf",       ALU_DIV_OP,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0};
    vecs[9]  = '{"rem_ovf",       ALU_REM_OP,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0};
    vecs[10] = '{"mulh_min_min",  ALU_MULH_OP,   32'h80000000, 32'h80000000, 32'h40000000, 34, 33};
    vecs[11] = '{"mul_shift4",    ALU_MUL_OP,    32'h12345678, 32'd16,       32'h23456780, 34, 33};
    vecs[12] = '{"remu_100_7",    ALU_REMU_OP,   32'd100,      32'd7,        32'd2,        34, 33};
    vecs[13] = '{"bad_op",        5'd3,          32'd5,        32'd6,        32'd0,        1,  0};
    vecs[14] = '{"divu_min_max",  ALU_DIVU_OP,   32'h80000000, 32'hFFFFFFFF, 32'd0,        34, 33};
    vecs[15] = '{"mulh_m1_5",     ALU_MULH_OP,   32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 34, 33};
    vecs[16] = '{"rem_7_m2",      ALU_REM_OP,    32'd7,        32'hFFFFFFFE, 32'd1,        34, 33};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #1;
    check("reset.result", result, '0);
    check("reset.busy",   {31'd0, busy}, 32'd0);
    check("reset.done",   {31'd0, done}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, edges, busy_n);
      check($sformatf("%s.result", vecs[i].name), res, vecs[i].exp);
      check($sformatf("%s.latency", vecs[i].name), edges, vecs[i].lat);
      check($sformatf("%s.busy_cycles", vecs[i].name), busy_n, vecs[i].bsy);
      @(posedge clock); #1;
      check($sformatf("%s.done_pulse", vecs[i].name), {31'd0, done}, 32'd0);
      check($sformatf("%s.result_hold", vecs[i].name), result, vecs[i].exp);
    end

    // start re-pulsed mid-divide with different operands must be ignored
    @(negedge clock);
    op = ALU_DIV_OP; a = 32'hFFFFFFF9; b = 32'd2; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    edges = 1;
    while (!done && edges < 200) begin
      if (edges == 10) begin
        op = ALU_MUL_OP; a = 32'd3; b = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      edges++;
    end
    check("ignore.latency", edges, 34);
    check("ignore.result", result, 32'hFFFFFFFD);
    @(posedge clock); #1;
    check("ignore.done_low", {31'd0, done}, 32'd0);
    check("ignore.idle_busy", {31'd0, busy}, 32'd0);

    // start held high: back-to-back requests accepted in DONE
    @(negedge clock);
    op = ALU_DIVU_OP; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    edges = 1;
    a = 32'd200;
    ndone = 0;
    while (ndone < 3 && edges < 300) begin
      if (done) begin
        held = (ndone == 0) ? 32'd14 : 32'd28;
        check($sformatf("b2b.result%0d", ndone), result, held);
        done_at[ndone] = edges;
        ndone++;
        if (ndone == 3) begin
          start = 1'b0;
        end else begin
          @(posedge clock); #1;
          edges++;
          check($sformatf("b2b.done_low%0d", ndone), {31'd0, done}, 32'd0);
          check($sformatf("b2b.hold%0d", ndone), result, held);
          check($sformatf("b2b.busy%0d", ndone), {31'd0, busy}, 32'd1);
        end
      end else begin
        @(posedge clock); #1;
        edges++;
      end
    end
    check("b2b.count", ndone, 3);
    check("b2b.first", done_at[0], 34);
    check("b2b.cadence1", done_at[1] - done_at[0], 34);
    check("b2b.cadence2", done_at[2] - done_at[1], 34);
    @(posedge clock); #1;
    check("b2b.end_done", {31'd0, done}, 32'd0);
    check("b2b.end_busy", {31'd0, busy}, 32'd0);

    // asynchronous reset in the middle of a multiply
    @(negedge clock);
    op = ALU_MUL_OP; a = 32'd7; b = 32'hFFFFFFFD; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #2;
    check("abort.busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort.busy",   {31'd0, busy}, 32'd0);
    check("abort.done",   {31'd0, done}, 32'd0);
    check("abort.result", result, '0);
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done || busy) ndone++;
    end
    check("abort.no_pending", ndone, 0);
    run_op(ALU_MUL_OP, 32'd6, 32'd7, res, edges, busy_n);
    check("after_abort.result", res, 32'd42);
    check("after_abort.latency", edges, 34);
    check("after_abort.busy_cycles", busy_n, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
